sprite_blitter: RTL
===================

# sprite_blitter

Parametrised successor to the fixed 12x6 brick drawer. It streams any rectangular sprite of configurable size from one of `N_TYPES` external image ROMs to the VGA write port. It adds transparency-key skipping, screen-edge clipping, a type-0 erase fill and a valid/ready pixel handshake with backpressure. Sits between the level/game FSM (which issues `start`) and the frame-buffer writer.

## Interface

- `SPR_W`, 12: sprite width in pixels (≥1)
- `SPR_H`, 6: sprite height in pixels (≥1)
- `N_TYPES`, 5: sprite types, including type 0 (erase)
- `COORD_W`, 8: screen coordinate width
- `COLOUR_W`, 24: pixel colour width
- `SCREEN_W`, 160 / `SCREEN_H`, 120: visible area; pixels at or beyond it are clipped
- `ROM_LAT`, 1: fixed external ROM read latency in cycles (≥1)
- `KEY_COLOUR`, 24'hFF00FF: transparent colour; never emitted for types ≥1
- `ERASE_COLOUR`, 24'hFFFFFF: fill colour for type 0
- `clk`  in  1  system clock
- `resetn`  in  1  asynchronous, active-low reset
- `start`  in  1  one-cycle request; sampled only when `busy`=0
- `sel`  in  clog2(N_TYPES)  sprite type, latched at `start`
- `x`, `y`  in  COORD_W  top-left origin, latched at `start`
- `busy`  out  1  high from the cycle after accepted `start` until `done`
- `done`  out  1  one-cycle pulse at end of draw
- `rom_sel`  out  clog2(N_TYPES)  latched type for the external ROM mux
- `rom_addr`  out  clog2(SPR_W*SPR_H)  row*SPR_W+col
- `rom_data`  in  COLOUR_W  valid ROM_LAT cycles after `rom_addr`
- `pix_valid`  out  1  pixel available
- `pix_ready`  in  1  consumer accepts the pixel when valid&&ready
- `pix_x`, `pix_y`  out  COORD_W  screen position
- `pix_colour`  out  COLOUR_W  pixel colour

## Operation

- FSM states: IDLE, FETCH, DRAIN, DONE.
  - IDLE→FETCH on `start`. Latch `sel`/`x`/`y`. Clear col/row counters.
  - FETCH: issue one address per cycle when a credit is free. Col counts 0..SPR_W-1, then wraps to 0 and row increments. After the address (SPR_H-1, SPR_W-1) is issued → DRAIN.
  - DRAIN: wait until the ROM pipe is empty and the FIFO is empty → DONE.
  - DONE: `done`=1 for one cycle → IDLE.
- `start` while `busy` is ignored. Inputs `sel`, `x`, `y` may change freely after `start`.
- A coordinate tag (col, row) travels in a ROM_LAT-deep valid/tag shift register alongside each fetch.
- Screen position: x+col and y+row, computed in COORD_W+1 bits.
  - If x+col ≥ SCREEN_W or y+row ≥ SCREEN_H, the pixel is dropped (not written to the FIFO). No wrap-around.
  - Clipped addresses may still be fetched.
- Type ≥1: if `rom_data`==KEY_COLOUR, the pixel is dropped.
- Type 0: colour = ERASE_COLOUR. `rom_data` is ignored. The key test does not apply.
- Credit rule: fetches in flight + FIFO occupancy must be ≤ FIFO depth (ROM_LAT+2). No pixel is ever lost under backpressure.
- Reset (any time, including mid-draw):
  - FSM→IDLE; pipe valids and FIFO are cleared; in-flight data is discarded.
  - Outputs: `busy`=0, `done`=0, `pix_valid`=0, `rom_addr`=0, `rom_sel`=0, `pix_x`/`pix_y`/`pix_colour`=0.

## Timing

- `start` in cycle 0 → `busy`=1 and first `rom_addr` valid in cycle 1.
- Address issued in cycle n → `rom_data` sampled in cycle n+ROM_LAT → pixel on `pix_*` in cycle n+ROM_LAT+1.
- Throughput: 1 pixel/cycle while `pix_ready`=1.
- Full opaque unclipped sprite with `pix_ready` high:
  - SPR_W*SPR_H consecutive valid cycles, first pixel in cycle ROM_LAT+2.
  - `done` in the cycle after the last handshake.
  - `busy` falls in the same cycle as `done` rises.
- If every pixel is dropped: `done` occurs ROM_LAT+2 cycles after the last fetch.
- `pix_*` must hold stable while `pix_valid`&&!`pix_ready`.

## Structure

- Package `sprite_pkg`:
  - sprite-type localparams NOBRICK=0, RED=1, BROWN=2, SRED=3, SBROWN=4
  - KEY/ERASE colour constants
  - FSM state enum
- Sub-module `pixel_fifo`: synchronous show-ahead FIFO, parametrised depth/width, with `count` output used for credits.
- The ROM instances stay outside this block; the top level muxes `rom_data` by `rom_sel`.

## Test plan

- Defaults, ROM_LAT=1, sel=1, x=10, y=20, all-opaque ROM, ready high → 72 pixels in raster order from (10,20) to (21,25). First pixel in cycle 3, `done` in cycle 75.
- ROM words 0..5 = KEY_COLOUR → 66 pixels emitted; (10..15,20) absent. `done` still pulses once.
- x=155, y=117 → only cols 0..4 and rows 0..2 are emitted (15 pixels). No coordinate wraps past 159/119.
- sel=0 with ROM returning garbage → 72 pixels, all 24'hFFFFFF.
- ROM_LAT=3, `pix_ready` random 50% → 72 pixels in exact order, none lost or duplicated. `pix_*` stable during stalls. `start` pulsed while busy is ignored.
- `resetn` low for 1 cycle after the 30th pixel → outputs zero immediately. No further `pix_valid` until the next `start`. A new draw completes normally.

Source files
------------

// File: rtl/sprite_pkg.sv
// Shared sprite types, colour constants and blitter FSM states.
package sprite_pkg;
    localparam int NOBRICK = 0;
    localparam int RED     = 1;
    localparam int BROWN   = 2;
    localparam int SRED    = 3;
    localparam int SBROWN  = 4;

    localparam logic [23:0] SPR_KEY_COLOUR   = 24'hFF00FF;
    localparam logic [23:0] SPR_ERASE_COLOUR = 24'hFFFFFF;

    typedef enum logic [1:0] {IDLE, FETCH, DRAIN, DONE} state_t;
endpackage

// File: rtl/pixel_fifo.sv
// Show-ahead FIFO: the head word sits on pop_dat whenever not empty.
// Latency: a word pushed in cycle n is visible in cycle n+1.
// Backpressure: no full flag; the producer keeps occupancy within DEPTH using count.
module pixel_fifo #(
    parameter int DEPTH = 3,
    parameter int WIDTH = 8,
    localparam int CNT_W = $clog2(DEPTH + 1),
    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
    input  logic             clk,
    input  logic             resetn,
    input  logic             push,
    input  logic [WIDTH-1:0] push_dat,
    input  logic             pop,
    output logic [WIDTH-1:0] pop_dat,
    output logic             empty,
    output logic [CNT_W-1:0] count
);
    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic             do_push;
    logic             do_pop;

    function automatic logic [PTR_W-1:0] next_ptr(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    assign empty   = (count == '0);
    assign do_pop  = pop && !empty;
    assign do_push = push && (count != CNT_W'(DEPTH));
    assign pop_dat = mem[rd_ptr];

    // Storage is cleared too, so the data outputs read zero straight out of reset.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
        end else begin
            if (do_push) begin
                mem[wr_ptr] <= push_dat;
                wr_ptr      <= next_ptr(wr_ptr);
            end
            if (do_pop) rd_ptr <= next_ptr(rd_ptr);
            count <= count + CNT_W'(do_push) - CNT_W'(do_pop);
        end
    end
endmodule

// File: rtl/sprite_blitter.sv
// Streams an SPR_W x SPR_H sprite from an external ROM to the pixel port, with key skipping and clipping.
// Latency: address issued in cycle n -> pixel on pix_* in cycle n+ROM_LAT+1; first address the cycle after start.
// Backpressure: fetches are credit-limited against the output FIFO, so pix_ready stalls never drop pixels.
module sprite_blitter
    import sprite_pkg::*;
#(
    parameter int SPR_W    = 12,
    parameter int SPR_H    = 6,
    parameter int N_TYPES  = 5,
    parameter int COORD_W  = 8,
    parameter int COLOUR_W = 24,
    parameter int SCREEN_W = 160,
    parameter int SCREEN_H = 120,
    parameter int ROM_LAT  = 1,
    parameter logic [COLOUR_W-1:0] KEY_COLOUR   = COLOUR_W'(SPR_KEY_COLOUR),
    parameter logic [COLOUR_W-1:0] ERASE_COLOUR = COLOUR_W'(SPR_ERASE_COLOUR),
    localparam int SEL_W  = (N_TYPES > 1) ? $clog2(N_TYPES) : 1,
    localparam int ADDR_W = (SPR_W * SPR_H > 1) ? $clog2(SPR_W * SPR_H) : 1
) (
    input  logic                clk,
    input  logic                resetn,
    input  logic                start,
    input  logic [SEL_W-1:0]    sel,
    input  logic [COORD_W-1:0]  x,
    input  logic [COORD_W-1:0]  y,
    output logic                busy,
    output logic                done,
    output logic [SEL_W-1:0]    rom_sel,
    output logic [ADDR_W-1:0]   rom_addr,
    input  logic [COLOUR_W-1:0] rom_data,
    output logic                pix_valid,
    input  logic                pix_ready,
    output logic [COORD_W-1:0]  pix_x,
    output logic [COORD_W-1:0]  pix_y,
    output logic [COLOUR_W-1:0] pix_colour
);
    localparam int COL_W = (SPR_W > 1) ? $clog2(SPR_W) : 1;
    localparam int ROW_W = (SPR_H > 1) ? $clog2(SPR_H) : 1;
    localparam int DEPTH = ROM_LAT + 2;
    localparam int CNT_W = $clog2(DEPTH + 1);
    localparam int SW    = COORD_W + 1;
    localparam int PW    = 2 * COORD_W + COLOUR_W;

    state_t               state;
    logic [COORD_W-1:0]   x_q;
    logic [COORD_W-1:0]   y_q;
    logic [COL_W-1:0]     col;
    logic [ROW_W-1:0]     row;
    logic                 fetch_vld;
    logic [ROM_LAT-1:0]   pipe_vld;
    logic [COL_W-1:0]     pipe_col [ROM_LAT];
    logic [ROW_W-1:0]     pipe_row [ROM_LAT];

    int                   in_pipe;
    logic                 pop;
    logic                 can_issue;
    logic                 last_addr;
    logic                 drained;
    logic                 keyed;
    logic [SW-1:0]        scr_x;
    logic [SW-1:0]        scr_y;
    logic [COLOUR_W-1:0]  colour;
    logic                 push;
    logic [PW-1:0]        push_dat;
    logic [PW-1:0]        fifo_q;
    logic                 fifo_empty;
    logic [CNT_W-1:0]     fifo_cnt;

    always_comb begin
        in_pipe = 0;
        for (int i = 0; i < ROM_LAT; i++) in_pipe += int'(pipe_vld[i]);
        pop = pix_valid && pix_ready;
        // A new fetch must still fit in the FIFO once everything in flight has landed.
        can_issue = (int'(fetch_vld) + in_pipe + int'(fifo_cnt) - int'(pop) + 1) <= DEPTH;
        last_addr = (col == COL_W'(SPR_W - 1)) && (row == ROW_W'(SPR_H - 1));
        drained   = (in_pipe == 0) && ((int'(fifo_cnt) - int'(pop)) == 0);
        scr_x     = SW'(x_q) + SW'(pipe_col[ROM_LAT-1]);
        scr_y     = SW'(y_q) + SW'(pipe_row[ROM_LAT-1]);
        keyed     = (rom_sel != SEL_W'(NOBRICK)) && (rom_data == KEY_COLOUR);
        colour    = (rom_sel == SEL_W'(NOBRICK)) ? ERASE_COLOUR : rom_data;
        push      = pipe_vld[ROM_LAT-1] && !keyed &&
                    (scr_x < SW'(SCREEN_W)) && (scr_y < SW'(SCREEN_H));
        push_dat  = {scr_x[COORD_W-1:0], scr_y[COORD_W-1:0], colour};
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state     <= IDLE;
            busy      <= 1'b0;
            done      <= 1'b0;
            rom_sel   <= '0;
            rom_addr  <= '0;
            x_q       <= '0;
            y_q       <= '0;
            col       <= '0;
            row       <= '0;
            fetch_vld <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    done <= 1'b0;
                    if (start) begin
                        state     <= FETCH;
                        busy      <= 1'b1;
                        rom_sel   <= sel;
                        x_q       <= x;
                        y_q       <= y;
                        col       <= '0;
                        row       <= '0;
                        rom_addr  <= '0;
                        fetch_vld <= 1'b1;
                    end
                end
                FETCH: begin
                    // fetch_vld marks rom_addr as issued this cycle; otherwise it is pending a credit.
                    if (fetch_vld && last_addr) begin
                        fetch_vld <= 1'b0;
                        state     <= DRAIN;
                    end else begin
                        if (fetch_vld) begin
                            rom_addr <= rom_addr + 1'b1;
                            if (col == COL_W'(SPR_W - 1)) begin
                                col <= '0;
                                row <= row + 1'b1;
                            end else begin
                                col <= col + 1'b1;
                            end
                        end
                        fetch_vld <= can_issue;
                    end
                end
                DRAIN: begin
                    if (drained) begin
                        state <= DONE;
                        busy  <= 1'b0;
                        done  <= 1'b1;
                    end
                end
                DONE: begin
                    done  <= 1'b0;
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    // Coordinate tags ride alongside the ROM read so they line up with rom_data.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            pipe_vld <= '0;
            for (int i = 0; i < ROM_LAT; i++) begin
                pipe_col[i] <= '0;
                pipe_row[i] <= '0;
            end
        end else begin
            for (int i = ROM_LAT - 1; i > 0; i--) begin
                pipe_vld[i] <= pipe_vld[i-1];
                pipe_col[i] <= pipe_col[i-1];
                pipe_row[i] <= pipe_row[i-1];
            end
            pipe_vld[0] <= fetch_vld;
            pipe_col[0] <= col;
            pipe_row[0] <= row;
        end
    end

    pixel_fifo #(.DEPTH(DEPTH), .WIDTH(PW)) u_fifo (
        .clk      (clk),
        .resetn   (resetn),
        .push     (push),
        .push_dat (push_dat),
        .pop      (pop),
        .pop_dat  (fifo_q),
        .empty    (fifo_empty),
        .count    (fifo_cnt)
    );

    assign pix_valid = !fifo_empty;
    assign {pix_x, pix_y, pix_colour} = fifo_q;
endmodule
